// File: rtl/mcu_ctrl_if.sv
// Control bus between the multicycle MIPS controller and its datapath.
// The controller sits on the slave side; the datapath (or bench) is the master.
interface mcu_ctrl_if;
    logic       run;
    logic [5:0] Op;
    logic       Zero;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       MemtoReg;
    logic       RegDst;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] PCSource;
    logic       PCEn;
    logic [3:0] state;

    modport master (
        output run, Op, Zero,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
               PCSource, PCEn, state
    );

    modport slave (
        input  run, Op, Zero,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
               PCSource, PCEn, state
    );
endinterface

// File: rtl/mcu_ctrl.sv
// Moore control FSM for a multicycle MIPS datapath (lw/sw/R-type/beq/j/addi).
// The run input single-steps the machine; write strobes are suppressed while stalled.
module mcu_ctrl #(
    parameter bit HAS_ADDI = 1'b1
) (
    input  logic     clk,
    input  logic     rst,
    mcu_ctrl_if.slave bus
);
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_e;

    state_e state_q, state_d;

    logic pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic wr_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus.run) begin
            case (state_q)
                S_FETCH:  state_d = S_DECODE;
                S_DECODE: begin
                    case (bus.Op)
                        OP_LW, OP_SW: state_d = S_MEMADR;
                        OP_RTYPE:     state_d = S_EXEC;
                        OP_BEQ:       state_d = S_BRANCH;
                        OP_J:         state_d = S_JUMP;
                        OP_ADDI:      state_d = HAS_ADDI ? S_ADDIEX : S_FETCH;
                        default:      state_d = S_FETCH;
                    endcase
                end
                S_MEMADR: state_d = (bus.Op == OP_LW) ? S_MEMRD : S_MEMWR;
                S_MEMRD:  state_d = S_MEMWB;
                S_EXEC:   state_d = S_RWB;
                S_ADDIEX: state_d = S_ADDIWB;
                default:  state_d = S_FETCH;
            endcase
        end
    end

    // Raw per-state decode; write strobes are gated below.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                ir_write  = 1'b1;
                pc_write  = 1'b1;
                alu_src_b = 2'b01;
            end
            S_DECODE: alu_src_b = 2'b11;
            S_MEMADR, S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_RWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
            S_ADDIWB: reg_write = 1'b1;
            default: ;
        endcase
    end

    // Strobes only fire on a real step; reset also kills them since FETCH is the reset state.
    assign wr_en = bus.run & ~rst;

    assign bus.PCWrite     = pc_write & wr_en;
    assign bus.PCWriteCond = pc_write_cond & wr_en;
    assign bus.MemWrite    = mem_write & wr_en;
    assign bus.IRWrite     = ir_write & wr_en;
    assign bus.RegWrite    = reg_write & wr_en;
    assign bus.PCEn        = bus.PCWrite | (bus.PCWriteCond & bus.Zero);
    assign bus.IorD        = iord;
    assign bus.MemRead     = mem_read;
    assign bus.MemtoReg    = mem_to_reg;
    assign bus.RegDst      = reg_dst;
    assign bus.ALUSrcA     = alu_src_a;
    assign bus.ALUSrcB     = alu_src_b;
    assign bus.ALUOp       = alu_op;
    assign bus.PCSource    = pc_source;
    assign bus.state       = 4'(state_q);
endmodule

// File: doc/mcu_ctrl.md
MCU_CTRL -- requirements
Module: mcu_ctrl

Interface
REQ-001 Parameter: HAS_ADDI, default 1, meaning: 1 enables the addi path (states 10/11); 0 makes opcode 0x08 illegal.
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 run  input  1  step enable; the state advances only when run=1.
REQ-005 Op  input  6  opcode field from the instruction register.
REQ-006 Zero  input  1  ALU zero flag.
REQ-007 PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA  output  1 each  datapath controls.
REQ-008 ALUSrcB, ALUOp, PCSource  output  2 each  datapath selects.
REQ-009 PCEn  output  1  PCWrite | (PCWriteCond & Zero).
REQ-010 state  output  4  current state code, for debug.

Function
REQ-011 Moore FSM with these state codes: 0 FETCH, 1 DECODE, 2 MEMADR, 3 MEMRD, 4 MEMWB, 5 MEMWR, 6 EXEC, 7 RWB, 8 BRANCH, 9 JUMP, 10 ADDIEX, 11 ADDIWB.
REQ-012 Transitions, taken only when run=1:
- FETCH->DECODE.
- DECODE by Op: 0x23/0x2B->MEMADR; 0x00->EXEC; 0x04->BRANCH; 0x02->JUMP; 0x08->ADDIEX when HAS_ADDI=1.
- MEMADR: Op 0x23->MEMRD, otherwise MEMWR.
- MEMRD->MEMWB.
- EXEC->RWB.
- ADDIEX->ADDIWB.
- MEMWB, MEMWR, RWB, BRANCH, JUMP, ADDIWB->FETCH.
REQ-013 Illegal opcode in DECODE (any Op not listed in REQ-012) shall go to FETCH; no write enable is asserted for it.
REQ-014 When run=0 the state holds and PCWrite, PCWriteCond, MemWrite, IRWrite, RegWrite are forced to 0; mux selects, MemRead and IorD keep their state values.
REQ-015 Per-state outputs; any output not listed is 0:
- FETCH: MemRead, IRWrite, PCWrite, ALUSrcB=01, ALUOp=00, PCSource=00.
- DECODE: ALUSrcB=11, ALUOp=00.
- MEMADR: ALUSrcA, ALUSrcB=10, ALUOp=00.
- MEMRD: MemRead, IorD.
- MEMWB: RegWrite, MemtoReg, RegDst=0.
- MEMWR: MemWrite, IorD.
- EXEC: ALUSrcA, ALUSrcB=00, ALUOp=10.
- RWB: RegWrite, RegDst=1, MemtoReg=0.
- BRANCH: ALUSrcA, ALUSrcB=00, ALUOp=01, PCWriteCond, PCSource=01.
- JUMP: PCWrite, PCSource=10.
- ADDIEX: ALUSrcA, ALUSrcB=10, ALUOp=00.
- ADDIWB: RegWrite, RegDst=0, MemtoReg=0.
REQ-016 Outputs are combinational from state and run only; Op and Zero affect outputs only through PCEn and next-state.
REQ-017 Cycle counts per instruction with run held at 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
REQ-018 RegWrite is asserted for exactly one cycle per register-writing instruction, so the register file sees a single write.

Reset
REQ-019 While rst=1, state=FETCH (0) immediately and asynchronously, and all write enables (PCWrite, PCWriteCond, MemWrite, IRWrite, RegWrite, PCEn) are 0.
REQ-020 After rst deasserts, the first rising edge with run=1 performs FETCH.
REQ-021 Reset asserted in any state, including mid-instruction, aborts the instruction with no further writes.

Verification
REQ-022 lw: rst pulse, run=1, Op=0x23 -> states 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4.
REQ-023 beq: Op=0x04 with Zero=1 -> PCEn=1 in state 8. Same with Zero=0 -> PCEn=0 in state 8. Both return to 0 after 3 cycles.
REQ-024 Stepping: R-type with run toggled 1,0,0,1,1,1 -> state holds during run=0; RegWrite pulses once, in RWB with run=1.
REQ-025 Illegal Op=0x3F, and Op=0x08 with HAS_ADDI=0 -> states 0,1,0; MemWrite and RegWrite never asserted.
REQ-026 Reset mid-instruction: assert rst in state 5 between clock edges -> state=0 and MemWrite=0 before the next edge.
REQ-027 Back-to-back run: sw then j -> 0,1,2,5,0,1,9,0; MemWrite high one cycle, PCWrite high in each FETCH and in JUMP.
